secuenciador_spwm: RTL and testbench

SECUENCIADOR_SPWM -- requirements
Module: secuenciador_spwm

---
 rtl/spwm_pkg.sv | 25 ++
 rtl/tabla_seno.sv | 35 +++
 rtl/secuenciador_spwm.sv | 139 +++++++++++++
 tb/tb_secuenciador_spwm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared types and constants for the SPWM sequencer: FSM state, index/amplitude widths
// and the quarter-wave address fold.
package spwm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } estado_e;

    localparam int unsigned AnchoIndice = 8;
    localparam int unsigned AnchoAmp    = 9;
    localparam int unsigned AmpPlena    = 256;
    localparam int unsigned AmpShift    = 8;

    function automatic logic [AnchoAmp-1:0] satura_amp(input logic [AnchoAmp-1:0] a);
        return (a > AnchoAmp'(AmpPlena)) ? AnchoAmp'(AmpPlena) : a;
    endfunction

    // Second and fourth quarters read the table backwards: 63 - idx[5:0] == ~idx[5:0].
    function automatic logic [5:0] dir_cuarto(input logic [AnchoIndice-1:0] idx);
        return idx[6] ? ~idx[5:0] : idx[5:0];
    endfunction

endpackage

// File: rtl/tabla_seno.sv
// Quarter-wave sine ROM, 64 entries of round(contador_pulsos_pwm*sin((k+0.5)*pi/128)),
// one-cycle registered read.
module tabla_seno #(
    parameter int unsigned Ancho_contador      = 14,
    parameter int unsigned contador_pulsos_pwm = 10000
) (
    input  logic                      clock,
    input  logic [5:0]                addr,
    output logic [Ancho_contador-1:0] data
);

    // Entries for a full scale of 10000; other full scales are rescaled at elaboration.
    localparam int unsigned BaseSeno [64] = '{
        123,  368,  613,  858,  1102, 1346, 1589, 1830,
        2071, 2311, 2549, 2785, 3020, 3253, 3484, 3713,
        3940, 4164, 4386, 4605, 4822, 5035, 5246, 5453,
        5657, 5858, 6055, 6249, 6438, 6624, 6806, 6984,
        7157, 7327, 7491, 7652, 7807, 7958, 8105, 8246,
        8382, 8514, 8640, 8761, 8876, 8987, 9092, 9191,
        9285, 9373, 9456, 9533, 9604, 9670, 9729, 9783,
        9831, 9873, 9909, 9939, 9963, 9981, 9993, 9999
    };

    logic [Ancho_contador-1:0] rom [64];

    for (genvar k = 0; k < 64; k++) begin : g_rom
        assign rom[k] = Ancho_contador'((BaseSeno[k] * contador_pulsos_pwm + 32'd5000)
                                        / 32'd10000);
    end

    always_ff @(posedge clock) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/secuenciador_spwm.sv
// SPWM sequencer: steps a 256-sample sine through the PWM duty word, one sample per carrier
// period. Amplitude scaling is built only when SPWM_AMP_SCALE_EN is defined.
module secuenciador_spwm
    import spwm_pkg::*;
#(
    parameter int unsigned Ancho_contador      = 14,
    parameter int unsigned contador_pulsos_pwm = 10000,
    parameter int unsigned Muestras_cuarto     = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [AnchoAmp-1:0]       amp_in,
    input  logic                      carry_pwm,
    output logic [Ancho_contador-1:0] duty,
    output logic                      e_pwm,
    output logic                      rst_syn_pwm,
    output logic                      polaridad,
    output logic                      busy,
    output logic                      fin_periodo
);

    if (Muestras_cuarto != 64) begin : g_param_check
        $error("tabla_seno holds exactly 64 quarter-wave samples");
    end

    estado_e                   state_q, state_d;
    logic [AnchoIndice-1:0]    idx_q, idx_d, idx_sig, idx_rom;
    logic [Ancho_contador-1:0] duty_q, duty_d, rom_data, muestra;
    logic                      e_pwm_q, e_pwm_d, rst_syn_q, rst_syn_d;
    logic                      pol_q, pol_d, fin_q, fin_d;
    logic                      wrap;
    logic [5:0]                dir;

    assign idx_sig = idx_q + AnchoIndice'(1);
    // The ROM always prefetches the sample the next load will need.
    assign idx_rom = (state_q == StIdle) ? '0 : idx_sig;
    assign dir     = dir_cuarto(idx_rom);
    assign wrap    = carry_pwm && (idx_q == '1) && (state_q != StIdle);

    tabla_seno #(
        .Ancho_contador     (Ancho_contador),
        .contador_pulsos_pwm(contador_pulsos_pwm)
    ) u_tabla (
        .clock(clock),
        .addr (dir),
        .data (rom_data)
    );

`ifdef SPWM_AMP_SCALE_EN
    logic [AnchoAmp-1:0]                amp_q, amp_eff;
    logic [Ancho_contador+AnchoAmp-1:0] producto;

    // New amplitude is taken only at start (while idle) and on the 255 -> 0 wrap.
    assign amp_eff  = (state_q == StIdle || wrap) ? satura_amp(amp_in) : amp_q;
    assign producto = {{AnchoAmp{1'b0}}, rom_data} * {{Ancho_contador{1'b0}}, amp_eff};
    assign muestra  = Ancho_contador'(producto >> AmpShift);

    always_ff @(posedge clock) begin
        if (!reset) amp_q <= AnchoAmp'(AmpPlena);
        else        amp_q <= amp_eff;
    end
`else
    logic amp_unused;
    assign amp_unused = ^amp_in;
    assign muestra    = rom_data;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        duty_d    = duty_q;
        e_pwm_d   = e_pwm_q;
        rst_syn_d = rst_syn_q;
        pol_d     = pol_q;
        fin_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d   = StRun;
                    idx_d     = '0;
                    duty_d    = muestra;
                    e_pwm_d   = 1'b1;
                    rst_syn_d = 1'b0;
                    pol_d     = 1'b0;
                end
            end
            StRun, StStopping: begin
                if (state_q == StRun && stop) state_d = StStopping;
                if (carry_pwm) begin
                    idx_d  = idx_sig;
                    duty_d = muestra;
                    pol_d  = idx_sig[AnchoIndice-1];
                end
                if (wrap) begin
                    fin_d = 1'b1;
                    if (state_q == StStopping) begin
                        state_d   = StIdle;
                        idx_d     = '0;
                        duty_d    = '0;
                        e_pwm_d   = 1'b0;
                        rst_syn_d = 1'b1;
                        pol_d     = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            duty_q    <= '0;
            e_pwm_q   <= 1'b0;
            rst_syn_q <= 1'b1;
            pol_q     <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            duty_q    <= duty_d;
            e_pwm_q   <= e_pwm_d;
            rst_syn_q <= rst_syn_d;
            pol_q     <= pol_d;
            fin_q     <= fin_d;
        end
    end

    assign duty        = duty_q;
    assign e_pwm       = e_pwm_q;
    assign rst_syn_pwm = rst_syn_q;
    assign polaridad   = pol_q;
    assign fin_periodo = fin_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_secuenciador_spwm.sv
// Directed bench for secuenciador_spwm: sine walk, mirroring, polarity, amplitude sampling,
// stop at period boundary and reset behaviour.
module tb_secuenciador_spwm;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [8:0]  amp_in;
    logic        carry_pwm;
    logic [13:0] duty;
    logic        e_pwm;
    logic        rst_syn_pwm;
    logic        polaridad;
    logic        busy;
    logic        fin_periodo;

    int n_checks = 0;
    int n_fail   = 0;
    int fin_count = 0;
    int fin_base;
    int cur;

    secuenciador_spwm dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .amp_in     (amp_in),
        .carry_pwm  (carry_pwm),
        .duty       (duty),
        .e_pwm      (e_pwm),
        .rst_syn_pwm(rst_syn_pwm),
        .polaridad  (polaridad),
        .busy       (busy),
        .fin_periodo(fin_periodo)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (fin_periodo === 1'b1) fin_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Two idle cycles let the ROM prefetch settle, then one carry pulse.
    task automatic do_carry();
        tick();
        tick();
        carry_pwm = 1'b1;
        tick();
        carry_pwm = 1'b0;
        cur = (cur + 1) % 256;
    endtask

    task automatic advance_to(input int target);
        while (cur != target) do_carry();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cur = 0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " duty"},  32'(duty), 32'd0);
        check_eq({tag, " e_pwm"}, 32'(e_pwm), 32'd0);
        check_eq({tag, " rst"},   32'(rst_syn_pwm), 32'd1);
        check_eq({tag, " pol"},   32'(polaridad), 32'd0);
        check_eq({tag, " busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        carry_pwm = 1'b0;
        amp_in    = 9'd256;
        cur       = 0;
        repeat (3) tick();

        // Start while reset is held is ignored.
        pulse_start();
        tick();
        check_idle("rst_held");
        check_eq("rst_held fin", 32'(fin_periodo), 32'd0);

        reset = 1'b1;
        repeat (2) tick();

        pulse_start();
        check_eq("start duty", 32'(duty), 32'd123);
        check_eq("start e_pwm", 32'(e_pwm), 32'd1);
        check_eq("start rst", 32'(rst_syn_pwm), 32'd0);
        check_eq("start busy", 32'(busy), 32'd1);
        advance_to(1);
        check_eq("idx1 duty", 32'(duty), 32'd368);
        advance_to(63);
        check_eq("idx63 duty", 32'(duty), 32'd9999);
        advance_to(64);
        check_eq("idx64 duty", 32'(duty), 32'd9999);
        advance_to(65);
        check_eq("idx65 duty", 32'(duty), 32'd9993);
        check_eq("idx65 pol", 32'(polaridad), 32'd0);
        advance_to(128);
        check_eq("idx128 duty", 32'(duty), 32'd123);
        check_eq("idx128 pol", 32'(polaridad), 32'd1);
        advance_to(200);
        check_eq("idx200 duty", 32'(duty), 32'd9783);
        check_eq("idx200 pol", 32'(polaridad), 32'd1);
        check_eq("no wrap yet", 32'(fin_count), 32'd0);

        // Reset mid-period.
        reset = 1'b0;
        tick();
        check_idle("rst_mid");
        reset = 1'b1;
        tick();

        // Start and stop together stay idle.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        check_idle("start_stop");

        // Amplitude sampled at start and at wrap only.
        amp_in = 9'd128;
        pulse_start();
`ifdef SPWM_AMP_SCALE_EN
        check_eq("amp128 duty0", 32'(duty), 32'd61);
        advance_to(100);
        check_eq("amp128 idx100", 32'(duty), 32'd3124);
        amp_in = 9'd256;
        advance_to(101);
        check_eq("amp hold idx101", 32'(duty), 32'd3027);
        advance_to(255);
        check_eq("amp hold idx255", 32'(duty), 32'd61);
`else
        check_eq("amp128 duty0", 32'(duty), 32'd123);
        advance_to(100);
        check_eq("amp128 idx100", 32'(duty), 32'd6249);
        amp_in = 9'd256;
        advance_to(101);
        check_eq("amp hold idx101", 32'(duty), 32'd6055);
        advance_to(255);
        check_eq("amp hold idx255", 32'(duty), 32'd123);
`endif
        check_eq("idx255 pol", 32'(polaridad), 32'd1);
        do_carry();
        check_eq("wrap duty", 32'(duty), 32'd123);
        check_eq("wrap pol", 32'(polaridad), 32'd0);
        check_eq("wrap fin", 32'(fin_periodo), 32'd1);
        check_eq("wrap busy", 32'(busy), 32'd1);

        // Stop mid-period runs out to the boundary; start/stop there are ignored.
        advance_to(40);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stopping busy", 32'(busy), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        advance_to(255);
        check_eq("stop idx255 busy", 32'(busy), 32'd1);
        check_eq("stop idx255 e_pwm", 32'(e_pwm), 32'd1);
        check_eq("stop idx255 duty", 32'(duty), 32'd123);
        fin_base = fin_count;
        do_carry();
        check_idle("stop_end");
        check_eq("stop_end fin", 32'(fin_periodo), 32'd1);
        repeat (3) tick();
        check_eq("stop_end fin count", 32'(fin_count - fin_base), 32'd1);
        check_eq("stop_end fin low", 32'(fin_periodo), 32'd0);
        do_carry();
        check_idle("idle carry");

        // Amplitude above full scale saturates.
        amp_in = 9'd511;
        pulse_start();
        check_eq("amp sat duty0", 32'(duty), 32'd123);
        advance_to(63);
        check_eq("amp sat idx63", 32'(duty), 32'd9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
